// File: rtl/de_pipe_reg_if.sv
// Decode-to-execute handshake bundle: D-side fields driven by decode,
// registered E-side fields and performance counters returned by the pipe register.
interface de_pipe_reg_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
);
  logic                      EnD;
  logic                      FlushE;
  logic                      CntClr;
  logic                      ValidD;
  logic [DATA_WIDTH-1:0]     RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [REG_ADDR_WIDTH-1:0] RdD, Rs1D, Rs2D;
  logic                      RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD;
  logic [1:0]                ResultSrcD;
  logic [ALU_CTRL_WIDTH-1:0] ALUControlD;

  logic [DATA_WIDTH-1:0]     RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [REG_ADDR_WIDTH-1:0] RdE, Rs1E, Rs2E;
  logic                      RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
  logic [1:0]                ResultSrcE;
  logic [ALU_CTRL_WIDTH-1:0] ALUControlE;
  logic                      ValidE;
  logic [CNT_WIDTH-1:0]      StallCnt, BubbleCnt;

  modport master (
    output EnD, FlushE, CntClr, ValidD,
    output RD1D, RD2D, PCD, ImmExtD, PCPlus4D, RdD, Rs1D, Rs2D,
    output RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD, ALUControlD,
    input  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, Rs1E, Rs2E,
    input  RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUControlE,
    input  ValidE, StallCnt, BubbleCnt
  );

  modport slave (
    input  EnD, FlushE, CntClr, ValidD,
    input  RD1D, RD2D, PCD, ImmExtD, PCPlus4D, RdD, Rs1D, Rs2D,
    input  RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD, ALUControlD,
    output RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, Rs1E, Rs2E,
    output RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUControlE,
    output ValidE, StallCnt, BubbleCnt
  );
endinterface

// File: rtl/de_pipe_reg.sv
// Decode-to-execute pipeline register with stall/flush control and
// saturating stall/bubble counters for performance debug.
module de_pipe_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input logic          clk,
  input logic          rst,
  de_pipe_reg_if.slave bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc4;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic                      reg_write;
    logic                      mem_write;
    logic                      branch;
    logic                      jump;
    logic                      alu_src;
    logic [1:0]                result_src;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
    logic                      valid;
  } stage_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1);
    end
  endfunction

  stage_t               d_fields_s;
  stage_t               e_next_s;
  stage_t               e_fields_r;
  logic                 stall_inc_s;
  logic                 bubble_inc_s;
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic [CNT_WIDTH-1:0] bubble_cnt_r;

  assign d_fields_s = '{
    rd1: bus.RD1D, rd2: bus.RD2D, pc: bus.PCD, imm: bus.ImmExtD, pc4: bus.PCPlus4D,
    rd: bus.RdD, rs1: bus.Rs1D, rs2: bus.Rs2D,
    reg_write: bus.RegWriteD, mem_write: bus.MemWriteD, branch: bus.BranchD,
    jump: bus.JumpD, alu_src: bus.ALUSrcD, result_src: bus.ResultSrcD,
    alu_ctrl: bus.ALUControlD, valid: bus.ValidD
  };

  // Next E-stage contents: flush beats capture, otherwise hold.
  always_comb begin
    e_next_s     = e_fields_r;
    stall_inc_s  = 1'b0;
    bubble_inc_s = 1'b0;
    if (bus.FlushE) begin
      e_next_s     = '0;
      bubble_inc_s = 1'b1;
    end else if (bus.EnD) begin
      e_next_s     = d_fields_s;
      bubble_inc_s = ~bus.ValidD;
    end else begin
      e_next_s    = e_fields_r;
      stall_inc_s = e_fields_r.valid;
    end
  end

  // E-stage field register.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_fields_r <= '0;
    end else begin
      e_fields_r <= e_next_s;
    end
  end

  // Saturating counters; clear wins over a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst || bus.CntClr) begin
      stall_cnt_r  <= '0;
      bubble_cnt_r <= '0;
    end else begin
      stall_cnt_r  <= stall_inc_s  ? sat_inc(stall_cnt_r)  : stall_cnt_r;
      bubble_cnt_r <= bubble_inc_s ? sat_inc(bubble_cnt_r) : bubble_cnt_r;
    end
  end

  assign bus.RD1E        = e_fields_r.rd1;
  assign bus.RD2E        = e_fields_r.rd2;
  assign bus.PCE         = e_fields_r.pc;
  assign bus.ImmExtE     = e_fields_r.imm;
  assign bus.PCPlus4E    = e_fields_r.pc4;
  assign bus.RdE         = e_fields_r.rd;
  assign bus.Rs1E        = e_fields_r.rs1;
  assign bus.Rs2E        = e_fields_r.rs2;
  assign bus.RegWriteE   = e_fields_r.reg_write;
  assign bus.MemWriteE   = e_fields_r.mem_write;
  assign bus.BranchE     = e_fields_r.branch;
  assign bus.JumpE       = e_fields_r.jump;
  assign bus.ALUSrcE     = e_fields_r.alu_src;
  assign bus.ResultSrcE  = e_fields_r.result_src;
  assign bus.ALUControlE = e_fields_r.alu_ctrl;
  assign bus.ValidE      = e_fields_r.valid;
  assign bus.StallCnt    = stall_cnt_r;
  assign bus.BubbleCnt   = bubble_cnt_r;

endmodule
